// File: rtl/execute_stage.sv
// Execute/writeback stage: register file, ALU, branch resolution, LW/SW handshake.
// Ports: decoded fields in (rd, rs1, rs2, imm, code, isLoad, isBranch,
//   writeEnabled, pcOut); redirect out (pcBranch, originPc); stall;
//   data-memory handshake (dReq, dWe, dAddr, dWdata, dAck, dRdata).
// Optional: define EXECUTE_INSTRET_EN to add a 64-bit instret output.
module execute_stage #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int DADDRLEN = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [XLEN-1:0]     imm,
    input  logic [11:0]         code,
    input  logic                isLoad,
    input  logic                isBranch,
    input  logic                writeEnabled,
    input  logic [31:0]         pcOut,
    output logic [31:0]         pcBranch,
    output logic                originPc,
    output logic                stall,
    output logic                dReq,
    output logic                dWe,
    output logic [DADDRLEN-1:0] dAddr,
    output logic [XLEN-1:0]     dWdata,
    input  logic                dAck,
    input  logic [XLEN-1:0]     dRdata
`ifdef EXECUTE_INSTRET_EN
    ,
    output logic [63:0]         instret
`endif
);

    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;

    typedef enum logic {EXEC = 1'b0, MEM_WAIT = 1'b1} state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]     rf_q [NREGS];
    logic [31:0]         pcBranch_q;
    logic                originPc_q;
    logic                dWe_q;
    logic [DADDRLEN-1:0] dAddr_q;
    logic [XLEN-1:0]     dWdata_q;
    logic [4:0]          ld_rd_q;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [XLEN-1:0] rs1_v, rs2_v, alu_b, alu_r, sra_r, ea, wr_val;
    logic [4:0]      shamt;
    logic [31:0]     tgt;
    logic            fire, taken, wr_en, redir, mem_go;

    assign opc   = code[6:0];
    assign f3    = code[9:7];
    assign rs1_v = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_v = (rs2 == 5'd0) ? '0 : rf_q[rs2];
    assign ea    = rs1_v + imm;

    // The cycle after a redirect is the branch shadow: whatever is
    // presented then was fetched down the wrong path.
    assign fire  = writeEnabled && !originPc_q && (state_q == EXEC);

    always_comb begin
        alu_b = (opc == OP_OP) ? rs2_v : imm;
        shamt = alu_b[4:0];
        sra_r = $signed(rs1_v) >>> shamt;
        alu_r = '0;
        unique case (f3)
            3'b000: alu_r = (opc == OP_OP && code[11]) ?
                            rs1_v - alu_b : rs1_v + alu_b;
            3'b001: alu_r = rs1_v << shamt;
            3'b010: alu_r = {{(XLEN-1){1'b0}},
                             $signed(rs1_v) < $signed(alu_b)};
            3'b011: alu_r = {{(XLEN-1){1'b0}}, rs1_v < alu_b};
            3'b100: alu_r = rs1_v ^ alu_b;
            3'b101: alu_r = code[11] ? sra_r : (rs1_v >> shamt);
            3'b110: alu_r = rs1_v | alu_b;
            3'b111: alu_r = rs1_v & alu_b;
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  taken = (rs1_v == rs2_v);
            3'b001:  taken = (rs1_v != rs2_v);
            3'b100:  taken = $signed(rs1_v) < $signed(rs2_v);
            3'b101:  taken = !($signed(rs1_v) < $signed(rs2_v));
            3'b110:  taken = rs1_v < rs2_v;
            3'b111:  taken = !(rs1_v < rs2_v);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_val = alu_r;
        redir  = 1'b0;
        tgt    = pcOut + imm;
        mem_go = 1'b0;
        if (fire) begin
            case (opc)
                OP_OP:    wr_en = !code[10];
                OP_IMM:   wr_en = 1'b1;
                OP_LUI: begin
                    wr_en  = 1'b1;
                    wr_val = imm;
                end
                OP_AUIPC: begin
                    wr_en  = 1'b1;
                    wr_val = pcOut + imm;
                end
                OP_JAL: begin
                    wr_en  = 1'b1;
                    wr_val = pcOut + 32'd4;
                    redir  = isBranch;
                end
                OP_JALR: begin
                    wr_en  = 1'b1;
                    wr_val = pcOut + 32'd4;
                    redir  = isBranch;
                    tgt    = {ea[31:1], 1'b0};
                end
                OP_BR:    redir  = isBranch && taken;
                OP_LD,
                OP_ST:    mem_go = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= EXEC;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EXEC:     if (mem_go) state_d = MEM_WAIT;
            MEM_WAIT: if (dAck)   state_d = EXEC;
        endcase
    end

    always_comb begin
        stall = (state_q == MEM_WAIT);
        dReq  = (state_q == MEM_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcBranch_q <= '0;
            originPc_q <= 1'b0;
            dWe_q      <= 1'b0;
            dAddr_q    <= '0;
            dWdata_q   <= '0;
            ld_rd_q    <= '0;
        end else begin
            originPc_q <= redir;
            if (redir) pcBranch_q <= tgt;
            if (mem_go) begin
                dWe_q    <= !isLoad;
                dAddr_q  <= {ea[DADDRLEN-1:2], 2'b00};
                dWdata_q <= rs2_v;
                ld_rd_q  <= rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wr_en && rd != 5'd0) begin
            rf_q[rd] <= wr_val;
        end else if (state_q == MEM_WAIT && dAck && !dWe_q &&
                     ld_rd_q != 5'd0) begin
            rf_q[ld_rd_q] <= dRdata;
        end
    end

    assign pcBranch = pcBranch_q;
    assign originPc = originPc_q;
    assign dWe      = dWe_q;
    assign dAddr    = dAddr_q;
    assign dWdata   = dWdata_q;

`ifdef EXECUTE_INSTRET_EN
    logic [63:0] instret_q;
    logic        retire;

    assign retire = (fire && (wr_en || opc == OP_BR)) ||
                    (state_q == MEM_WAIT && dAck);

    always_ff @(posedge clk) begin
        if (reset)       instret_q <= '0;
        else if (retire) instret_q <= instret_q + 64'd1;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus random stream
// compared every cycle against an instruction-level reference model.
module tb_execute_stage;

    localparam logic [6:0] OPR = 7'h33, OPI = 7'h13, LUI = 7'h37, AUI = 7'h17;
    localparam logic [6:0] JAL = 7'h6f, JALR = 7'h67, BR = 7'h63;
    localparam logic [6:0] LD = 7'h03, ST = 7'h23, BAD = 7'h0b;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [11:0] code;
    logic        isLoad, isBranch, writeEnabled;
    logic [31:0] pcOut;
    logic [31:0] pcBranch;
    logic        originPc, stall, dReq, dWe;
    logic [11:0] dAddr;
    logic [31:0] dWdata;
    logic        dAck;
    logic [31:0] dRdata;
`ifdef EXECUTE_INSTRET_EN
    logic [63:0] instret;
`endif

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .reset(reset), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .code(code), .isLoad(isLoad), .isBranch(isBranch),
        .writeEnabled(writeEnabled), .pcOut(pcOut),
        .pcBranch(pcBranch), .originPc(originPc), .stall(stall),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dAck(dAck), .dRdata(dRdata)
`ifdef EXECUTE_INSTRET_EN
        , .instret(instret)
`endif
    );

    logic [31:0] m_rf [32];
    logic        m_redir, m_busy, m_we;
    logic [31:0] m_pcb, m_wdata;
    logic [11:0] m_addr;
    logic [4:0]  m_ldrd;
    logic [63:0] m_ir;
    int total = 0;
    int bad = 0;

    function automatic logic [31:0] m_alu(input logic [2:0] f,
        input logic [31:0] a, input logic [31:0] b,
        input logic alt, input logic isop);
        int n;
        n = int'(b[4:0]);
        case (f)
            3'd0: return (isop && alt) ? a + (~b + 32'd1) : a + b;
            3'd1: return a << n;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: if (alt)
                      return (a >> n) | (a[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
                  else
                      return a >> n;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic m_taken(input logic [2:0] f,
        input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic mw(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_rf[r] = v;
    endtask

    // Predicts state after the coming rising edge from the current inputs.
    task automatic model_update();
        logic [31:0] a, b, t;
        logic [6:0] op;
        logic [2:0] f;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_redir = 0; m_busy = 0; m_we = 0; m_pcb = 0;
            m_wdata = 0; m_addr = 0; m_ldrd = 0; m_ir = 0;
            return;
        end
        if (m_busy) begin
            m_redir = 0;
            if (dAck) begin
                if (!m_we) mw(m_ldrd, dRdata);
                m_busy = 0;
                m_ir = m_ir + 1;
            end
            return;
        end
        if (!writeEnabled || m_redir) begin
            m_redir = 0;
            return;
        end
        m_redir = 0;
        a = m_rf[rs1]; b = m_rf[rs2];
        op = code[6:0]; f = code[9:7];
        case (op)
            OPR: if (!code[10]) begin
                     mw(rd, m_alu(f, a, b, code[11], 1'b1)); m_ir = m_ir + 1;
                 end
            OPI: begin mw(rd, m_alu(f, a, imm, code[11], 1'b0)); m_ir = m_ir + 1; end
            LUI: begin mw(rd, imm); m_ir = m_ir + 1; end
            AUI: begin mw(rd, pcOut + imm); m_ir = m_ir + 1; end
            JAL: begin
                mw(rd, pcOut + 4); m_redir = 1; m_pcb = pcOut + imm;
                m_ir = m_ir + 1;
            end
            JALR: begin
                t = (a + imm) & 32'hFFFF_FFFE;
                mw(rd, pcOut + 4); m_redir = 1; m_pcb = t;
                m_ir = m_ir + 1;
            end
            BR: begin
                if (m_taken(f, a, b)) begin m_redir = 1; m_pcb = pcOut + imm; end
                m_ir = m_ir + 1;
            end
            LD, ST: begin
                t = (a + imm) & 32'h0000_0FFC;
                m_busy = 1; m_we = (op == ST); m_addr = t[11:0];
                m_wdata = b; m_ldrd = rd;
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        int nb, first;
        chk("originPc", originPc, m_redir);
        chk("pcBranch", pcBranch, m_pcb);
        chk("stall", stall, m_busy);
        chk("dReq", dReq, m_busy);
        if (m_busy) begin
            chk("dWe", dWe, m_we);
            chk("dAddr", dAddr, m_addr);
            chk("dWdata", dWdata, m_wdata);
        end
        nb = 0; first = 0;
        for (int i = 0; i < 32; i++)
            if (dut.rf_q[i] !== m_rf[i]) begin
                if (nb == 0) first = i;
                nb++;
            end
        total++;
        if (nb != 0) begin
            bad++;
            $display("FAIL rf x%0d actual=%h required=%h", first,
                     dut.rf_q[first], m_rf[first]);
        end
`ifdef EXECUTE_INSTRET_EN
        chk("instret", instret, m_ir);
`endif
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic we, input logic [4:0] d,
        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
        input logic [11:0] c, input logic [31:0] pc);
        writeEnabled = we; rd = d; rs1 = s1; rs2 = s2; imm = im;
        code = c; pcOut = pc;
        isLoad = (c[6:0] == LD);
        isBranch = (c[6:0] == JAL) || (c[6:0] == JALR) || (c[6:0] == BR);
        dAck = 1'b0; dRdata = 32'd0;
    endtask

    function automatic logic [11:0] mk(input logic a7, input logic m7,
        input logic [2:0] f, input logic [6:0] op);
        return {a7, m7, f, op};
    endfunction

    logic [6:0] opt [11] = '{OPR, OPI, LUI, AUI, JAL, JALR, BR, LD, ST, OPI, BAD};

    initial begin
        logic [31:0] r, im;
        logic [4:0] rr [3];
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 12'd0, 0);
        step(); step();
        chk("rst_originPc", originPc, 0);
        chk("rst_stall", stall, 0);
        chk("rst_dReq", dReq, 0);
        reset = 1'b0;

        drive(1, 1, 0, 0, 5, mk(0, 0, 0, OPI), 0); step();
        chk("addi_x1", dut.rf_q[1], 32'd5);
        chk("addi_noredir", originPc, 0);
        drive(1, 2, 0, 0, 7, mk(0, 0, 0, OPI), 4); step();
        drive(1, 3, 1, 2, 0, mk(1, 0, 0, OPR), 8); step();
        chk("sub_x3", dut.rf_q[3], 32'hFFFF_FFFE);
        drive(1, 4, 3, 0, 32'h401, mk(1, 0, 5, OPI), 12); step();
        chk("sra_x4", dut.rf_q[4], 32'hFFFF_FFFF);

        drive(1, 0, 0, 0, 16, mk(0, 0, 0, BR), 32'h20); step();
        chk("beq_target", pcBranch, 32'h30);
        chk("beq_redir", originPc, 1);
        drive(1, 5, 0, 0, 1, mk(0, 0, 0, OPI), 32'h24); step();
        chk("shadow_pulse", originPc, 0);
        chk("shadow_x5", dut.rf_q[5], 0);

        drive(1, 1, 0, 0, 32'h100, mk(0, 0, 0, OPI), 32'h28); step();
        drive(1, 1, 1, 0, 3, mk(0, 0, 0, JALR), 32'h40); step();
        chk("jalr_target", pcBranch, 32'h102);
        chk("jalr_link", dut.rf_q[1], 32'h44);
        drive(0, 0, 0, 0, 0, 12'd0, 0); step();

        drive(1, 2, 0, 0, 32'hDEAD_C000, mk(0, 0, 0, LUI), 32'h48); step();
        drive(1, 2, 2, 0, 32'hFFFF_FEEF, mk(0, 0, 0, OPI), 32'h4c); step();
        drive(1, 0, 0, 2, 8, mk(0, 0, 2, ST), 32'h50); step();
        for (int k = 0; k < 3; k++) begin
            chk("sw_dReq", dReq, 1);
            chk("sw_dWe", dWe, 1);
            chk("sw_dAddr", dAddr, 12'd8);
            chk("sw_dWdata", dWdata, 32'hDEAD_BEEF);
            chk("sw_stall", stall, 1);
            drive(1, 9, 0, 0, 123, mk(0, 0, 0, OPI), 32'h54);
            if (k == 2) dAck = 1'b1;
            step();
        end
        chk("sw_done_dReq", dReq, 0);
        chk("sw_done_stall", stall, 0);
        chk("sw_ignored_x9", dut.rf_q[9], 0);

        drive(1, 6, 0, 0, 8, mk(0, 0, 2, LD), 32'h54); step();
        drive(0, 0, 0, 0, 0, 12'd0, 0);
        dAck = 1'b1; dRdata = 32'hDEAD_BEEF; step();
        chk("lw_x6", dut.rf_q[6], 32'hDEAD_BEEF);

        drive(1, 7, 0, 0, 8, mk(0, 0, 2, LD), 32'h58); step();
        drive(0, 0, 0, 0, 0, 12'd0, 0);
        reset = 1'b1; step();
        reset = 1'b0;
        chk("rstmem_dReq", dReq, 0);
        chk("rstmem_stall", stall, 0);
        chk("rstmem_x7", dut.rf_q[7], 0);
`ifdef EXECUTE_INSTRET_EN
        chk("rstmem_instret", instret, 0);
`endif

        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int j = 0; j < 3; j++)
                rr[j] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 7));
            r = $urandom;
            im = ($urandom_range(0, 3) == 0) ? r : {{20{r[11]}}, r[11:0]};
            drive($urandom_range(0, 9) != 0, rr[0], rr[1], rr[2], im,
                  mk(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                     3'($urandom_range(0, 7)), opt[$urandom_range(0, 10)]),
                  $urandom & 32'hFFFF_FFFC);
            dAck = ($urandom_range(0, 2) == 0);
            dRdata = $urandom;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Single-issue execute/writeback stage directly downstream of the instruction fetch/decode stage.
- Consumes decoded fields (rd, rs1, rs2, imm, code, isLoad, isBranch, writeEnabled, pcOut) and owns the 32-entry register file and the ALU.
- Runs the word-wide data-memory handshake.
- Returns the branch target (pcBranch) and redirect flag (originPc) to fetch.

Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, register file entries; x0 hardwired zero
- DADDRLEN, 12, data-memory byte-address width driven on dAddr

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd  in  5  destination register index
- rs1  in  5  source register 1 index
- rs2  in  5  source register 2 index
- imm  in  XLEN  sign-extended immediate
- code  in  12  {funct7[5], funct7[0], funct3[2:0], opcode[6:0]}
- isLoad  in  1  instruction is LOAD
- isBranch  in  1  instruction is BRANCH/JAL/JALR
- writeEnabled  in  1  instruction valid; 0 = squashed bubble
- pcOut  in  32  PC of presented instruction
- pcBranch  out  32  redirect target
- originPc  out  1  redirect request, one-cycle pulse
- stall  out  1  stage busy (load/store outstanding)
- dReq  out  1  data-memory request
- dWe  out  1  1 = store, 0 = load
- dAddr  out  DADDRLEN  byte address, word aligned
- dWdata  out  XLEN  store data
- dAck  in  1  memory completion
- dRdata  in  XLEN  load data, valid with dAck

Behaviour:
- Reset: all outputs 0, FSM = EXEC, all registers 0.
- FSM states: EXEC, MEM_WAIT.
- EXEC: on each rising edge with writeEnabled=1 and originPc=0, execute one instruction. writeEnabled=0 or originPc=1 means bubble: no register write, no redirect.
- Register reads are combinational; x0 reads 0. Writes to x0 are dropped.
- OP/OP-IMM: ADD/SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - Shift amount = low 5 bits.
  - Arithmetic wraps modulo 2^XLEN.
  - Result written to rd in the same edge.
- LUI: rd = imm.
- AUIPC: rd = pcOut + imm.
- JAL: rd = pcOut + 4; pcBranch = pcOut + imm.
- JALR: rd = pcOut + 4; pcBranch = (rs1 + imm) & ~1. Target computed from pre-write rs1 when rd == rs1.
- BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU): taken gives pcBranch = pcOut + imm.
- Redirect: taken branch or jump registers originPc=1 for exactly one cycle, then 0. pcBranch holds its value until the next redirect.
- LOAD (LW) / STORE (SW):
  - Register dReq=1, dWe, dAddr = (rs1 + imm)[DADDRLEN-1:0] & ~3, and dWdata = rs2.
  - Go to MEM_WAIT; stall=1.
- MEM_WAIT:
  - Hold dReq/dAddr/dWe/dWdata stable until dAck=1.
  - On dAck: load writes dRdata to the latched rd.
  - Then dReq=0, stall=0, return to EXEC the following edge.
  - Instructions presented while stall=1 are ignored (upstream honours stall).
- dAck while in EXEC: ignored.
- Unsupported opcode: treated as bubble (NOP).
- reset mid-MEM_WAIT: dReq drops next edge, pending load write discarded.
- Simultaneous redirect and writeEnabled=1 on next edge: that instruction is squashed (branch shadow).

Optional Feature:
- Macro EXECUTE_INSTRET_EN.
- Defined: adds output instret (64 bits).
  - Increments by 1 per retired instruction: non-bubble ALU/jump/branch in EXEC, or load/store on dAck.
  - Cleared by reset; wraps at 2^64.
- Undefined: port and counter absent; no other behavioural change.

Test Plan:
- Reset, then ADDI x1,x0,5 at pcOut=0 -> x1=5, originPc=0, stall=0.
- x1=5, x2=7, SUB x3,x1,x2 -> x3=0xFFFFFFFE; SRA x4,x3,1 -> x4=0xFFFFFFFF.
- BEQ x0,x0,+16 at pcOut=0x20 -> pcBranch=0x30, originPc=1 for one cycle; following writeEnabled=1 instruction ADDI x5,x0,1 not executed (x5 stays 0).
- JALR x1,x1,3 with x1=0x100 at pcOut=0x40 -> pcBranch=0x102, x1=0x44.
- SW x2,8(x0) with x2=0xDEADBEEF and dAck delayed 3 cycles -> dReq=1, dWe=1, dAddr=8, dWdata=0xDEADBEEF held 3 cycles, stall=1 throughout. Then LW x6,8(x0) with dRdata=0xDEADBEEF -> x6=0xDEADBEEF.
- LW in MEM_WAIT, reset asserted before dAck -> dReq=0 next edge, rd unchanged (0), FSM EXEC. With EXECUTE_INSTRET_EN: instret=0 after reset.
